fetch: RTL and testbench
========================

// Module: fetch
// PURPOSE
//  IF stage of the 5-stage pipelined MIPS. Owns the PC, runs a req/ack handshake to instruction memory
//  (one request outstanding) and presents one instruction per cycle to decode on FetchData_IF.
//  Takes redirects from decode (J/JAL) and execute (taken branch). Squashes wrong-path fetches; decode sees NOP_WORD.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded by reset
//  NOP_WORD  32'h0000_0000  word driven on FetchData_IF when no valid instruction (sll r0,r0,0)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   synchronous, active-high
//  AnyStall       in   1   pipeline stall; decode does not consume FetchData_IF this cycle
//  Jump_ID        in   1   decode sees J/JAL in FetchData_IF (combinational from FetchData_IF)
//  JumpTgt_ID     in   26  jump instr_index
//  BrTaken_EX     in   1   execute resolved a taken branch this cycle
//  BrTgt_EX       in   32  branch target; bits [1:0] ignored
//  ImemReq        out  1   instruction fetch request
//  ImemAddr       out  32  fetch address (= PC register), word aligned
//  ImemAck        in   1   ImemRdata valid, completes current request; only sampled while ImemReq=1
//  ImemRdata      in   32  instruction word
//  FetchData_IF   out  32  instruction to decode; NOP_WORD when FetchValid_IF=0
//  PcPlus4_IF     out  32  PC+4 of the instruction on FetchData_IF
//  FetchValid_IF  out  1   FetchData_IF holds a real, non-squashed instruction
//  FetchFlush_IF  out  1   = BrTaken_EX & ~reset; drives decode flush to kill the younger ID instruction
// BEHAVIOUR
//  State: PC[31:0], RedirPc[31:0], Buf[31:0], FSM {S_REQ, S_HAVE, S_DROP}. No delay slot.
//  Reset (sync): PC<=RESET_PC, state<=S_REQ, Buf<=NOP_WORD. While reset=1: ImemReq=0, FetchValid_IF=0,
//    FetchData_IF=NOP_WORD, FetchFlush_IF=0. Reset mid-transaction abandons it; any later ack is ignored
//    until ImemReq rises again.
//  ImemReq=1 in S_REQ and S_DROP. ImemAddr = PC, stable until ack. Memory ack latency is >=1 cycle.
//  FetchValid_IF = ~BrTaken_EX & ((S_REQ & ImemAck) | S_HAVE). FetchData_IF = ImemRdata in S_REQ, Buf in S_HAVE.
//  consume = FetchValid_IF & ~AnyStall.
//  NextSeq = Jump_ID ? {PcPlus4_IF[31:28], JumpTgt_ID, 2'b00} : PC+4.
//  Priority per cycle: reset > BrTaken_EX > consume > hold.
//  S_REQ:
//    BrTaken & ack:  PC<=BrTgt&~3, stay S_REQ (response discarded).
//    BrTaken & ~ack: RedirPc<=BrTgt&~3, ->S_DROP.
//    ack & consume:  PC<=NextSeq, stay S_REQ. Back-to-back 1-cycle acks give 1 instr/cycle.
//    ack & stall:    Buf<=ImemRdata, ->S_HAVE.
//    no ack:         hold.
//  S_HAVE:
//    BrTaken:  PC<=BrTgt&~3, ->S_REQ.
//    consume:  PC<=NextSeq, ->S_REQ.
//    else:     hold; Buf stable across any stall length.
//  S_DROP: waits out the stale request.
//    BrTaken (with or without ack): RedirPc<=BrTgt&~3. Newest redirect wins.
//    ack: PC <= BrTaken ? BrTgt&~3 : RedirPc, ->S_REQ. FetchValid_IF=0 throughout.
//  PcPlus4_IF = PC+4, modulo 2^32. PC wraps 32'hFFFF_FFFC -> 0.
//  Jump_ID is acted on only on a consume cycle. If BrTaken_EX coincides, the branch wins and the jump is dropped.
// TESTING
//  1. Reset, 1-cycle ack memory, no stalls -> ImemAddr 0,4,8,C on consecutive cycles; FetchValid_IF=1 from cycle 2.
//  2. Ack held off 3 cycles at PC=0x10 -> ImemAddr stays 0x10, FetchValid_IF=0 and FetchData_IF=0 until ack.
//  3. AnyStall=1 for 4 cycles on ack of 0x8C430004 -> FetchData_IF held at 0x8C430004;
//     consumed when stall drops; ImemAddr advances by 4.
//  4. FetchData_IF=J 0x0000040, PC=0x0 -> next ImemAddr=0x100; fall-through 0x4 never presented valid.
//  5. BrTaken_EX, BrTgt_EX=0x203, ack pending -> FetchFlush_IF=1 that cycle; stale ack discarded;
//     next ImemAddr=0x200.
//  6. Second BrTaken_EX (tgt 0x300) during S_DROP, then reset asserted mid-request -> fetch resumes at 0x300;
//     after reset, ImemAddr=RESET_PC and outputs are at reset values.

Source files
------------

// File: rtl/fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_if                                                        |
// | Brief    : Instruction-memory req/ack bus between the IF stage and imem.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface fetch_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemRdata;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemAck,
        input  ImemRdata
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemAck,
        output ImemRdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch                                                           |
// | Brief    : MIPS IF stage: PC, single-outstanding imem fetch, redirects.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        AnyStall,
    input  wire logic        Jump_ID,
    input  wire logic [25:0] JumpTgt_ID,
    input  wire logic        BrTaken_EX,
    input  wire logic [31:0] BrTgt_EX,
    fetch_if.master          imem,
    output logic      [31:0] FetchData_IF,
    output logic      [31:0] PcPlus4_IF,
    output logic             FetchValid_IF,
    output logic             FetchFlush_IF
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HAVE = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] redir_pc_q;
    logic [31:0] buf_q;

    logic [31:0] br_tgt;
    logic [31:0] next_seq;
    logic        ack;
    logic        consume;

    assign br_tgt     = BrTgt_EX & ~32'h0000_0003;
    assign PcPlus4_IF = pc_q + 32'd4;
    assign next_seq   = Jump_ID ? {PcPlus4_IF[31:28], JumpTgt_ID, 2'b00} : PcPlus4_IF;

    assign imem.ImemReq  = ~reset & ((state_q == S_REQ) | (state_q == S_DROP));
    assign imem.ImemAddr = pc_q;
    // Ack only means anything while a request is actually being driven.
    assign ack           = imem.ImemReq & imem.ImemAck;

    assign FetchValid_IF = ~reset & ~BrTaken_EX &
                           (((state_q == S_REQ) & ack) | (state_q == S_HAVE));
    assign FetchData_IF  = !FetchValid_IF      ? NOP_WORD :
                           (state_q == S_HAVE) ? buf_q    : imem.ImemRdata;
    assign FetchFlush_IF = BrTaken_EX & ~reset;
    assign consume       = FetchValid_IF & ~AnyStall;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= S_REQ;
            buf_q   <= NOP_WORD;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (BrTaken_EX && ack) begin
                        pc_q <= br_tgt;
                    end else if (BrTaken_EX) begin
                        redir_pc_q <= br_tgt;
                        state_q    <= S_DROP;
                    end else if (consume) begin
                        pc_q <= next_seq;
                    end else if (ack) begin
                        buf_q   <= imem.ImemRdata;
                        state_q <= S_HAVE;
                    end
                end
                S_HAVE: begin
                    if (BrTaken_EX) begin
                        pc_q    <= br_tgt;
                        state_q <= S_REQ;
                    end else if (consume) begin
                        pc_q    <= next_seq;
                        state_q <= S_REQ;
                    end
                end
                S_DROP: begin
                    // The stale request must complete before the redirect can issue.
                    if (BrTaken_EX) begin
                        redir_pc_q <= br_tgt;
                    end
                    if (ack) begin
                        pc_q    <= BrTaken_EX ? br_tgt : redir_pc_q;
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch                                                        |
// | Brief    : Directed self-checking bench for the fetch IF stage.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        AnyStall;
    logic        Jump_ID;
    logic [25:0] JumpTgt_ID;
    logic        BrTaken_EX;
    logic [31:0] BrTgt_EX;
    logic [31:0] FetchData_IF;
    logic [31:0] PcPlus4_IF;
    logic        FetchValid_IF;
    logic        FetchFlush_IF;

    int n_checks   = 0;
    int n_failures = 0;

    fetch_if imem_bus ();

    fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .AnyStall      (AnyStall),
        .Jump_ID       (Jump_ID),
        .JumpTgt_ID    (JumpTgt_ID),
        .BrTaken_EX    (BrTaken_EX),
        .BrTgt_EX      (BrTgt_EX),
        .imem          (imem_bus.master),
        .FetchData_IF  (FetchData_IF),
        .PcPlus4_IF    (PcPlus4_IF),
        .FetchValid_IF (FetchValid_IF),
        .FetchFlush_IF (FetchFlush_IF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then drive this cycle's inputs and let the outputs settle.
    task automatic cyc(input logic rst, input logic ack, input logic [31:0] rdata,
                       input logic stall, input logic jmp, input logic [25:0] jtgt,
                       input logic br, input logic [31:0] brtgt);
        @(posedge clk);
        #1;
        reset              = rst;
        imem_bus.ImemAck   = ack;
        imem_bus.ImemRdata = rdata;
        AnyStall           = stall;
        Jump_ID            = jmp;
        JumpTgt_ID         = jtgt;
        BrTaken_EX         = br;
        BrTgt_EX           = brtgt;
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"},   {31'd0, imem_bus.ImemReq}, 32'd0);
        chk({tag, "_valid"}, {31'd0, FetchValid_IF},    32'd0);
        chk({tag, "_data"},  FetchData_IF,              32'd0);
        chk({tag, "_flush"}, {31'd0, FetchFlush_IF},    32'd0);
    endtask

    initial begin
        reset = 1'b1;
        imem_bus.ImemAck = 1'b0; imem_bus.ImemRdata = 32'd0;
        AnyStall = 1'b0; Jump_ID = 1'b0; JumpTgt_ID = 26'd0;
        BrTaken_EX = 1'b0; BrTgt_EX = 32'd0;

        // Reset: outputs forced idle even with a branch and ack present
        cyc(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 1, 32'h0000_0040);
        chk_reset_outs("rst");
        chk("rst_addr", imem_bus.ImemAddr, 32'h0);

        // 1: streaming with back-to-back acks
        cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("t1_req0",   {31'd0, imem_bus.ImemReq}, 32'd1);
        chk("t1_addr0",  imem_bus.ImemAddr, 32'h0);
        chk("t1_valid0", {31'd0, FetchValid_IF}, 32'd0);
        cyc(0, 1, 32'h2001_0001, 0, 0, 0, 0, 0);
        chk("t1_valid1", {31'd0, FetchValid_IF}, 32'd1);
        chk("t1_data1",  FetchData_IF, 32'h2001_0001);
        chk("t1_pc4_1",  PcPlus4_IF, 32'h4);
        cyc(0, 1, 32'h2002_0002, 0, 0, 0, 0, 0);
        chk("t1_addr4",  imem_bus.ImemAddr, 32'h4);
        chk("t1_data2",  FetchData_IF, 32'h2002_0002);
        cyc(0, 1, 32'h2003_0003, 0, 0, 0, 0, 0);
        chk("t1_addr8",  imem_bus.ImemAddr, 32'h8);
        cyc(0, 1, 32'h2004_0004, 0, 0, 0, 0, 0);
        chk("t1_addrC",  imem_bus.ImemAddr, 32'hC);

        // 2: ack held off 3 cycles at 0x10
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 32'h1234_5678, 0, 0, 0, 0, 0);
            chk("t2_addr",  imem_bus.ImemAddr, 32'h10);
            chk("t2_valid", {31'd0, FetchValid_IF}, 32'd0);
            chk("t2_data",  FetchData_IF, 32'h0);
        end

        // 3: ack arrives during a 4-cycle stall
        cyc(0, 1, 32'h8C43_0004, 1, 0, 0, 0, 0);
        chk("t3_valid_ack", {31'd0, FetchValid_IF}, 32'd1);
        chk("t3_data_ack",  FetchData_IF, 32'h8C43_0004);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 32'hAAAA_AAAA, 1, 0, 0, 0, 0);
            chk("t3_hold_data", FetchData_IF, 32'h8C43_0004);
            chk("t3_hold_req",  {31'd0, imem_bus.ImemReq}, 32'd0);
            chk("t3_hold_addr", imem_bus.ImemAddr, 32'h10);
        end
        cyc(0, 0, 32'hAAAA_AAAA, 0, 0, 0, 0, 0);
        chk("t3_cons_valid", {31'd0, FetchValid_IF}, 32'd1);
        chk("t3_cons_data",  FetchData_IF, 32'h8C43_0004);
        cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("t3_next_addr", imem_bus.ImemAddr, 32'h14);
        chk("t3_next_req",  {31'd0, imem_bus.ImemReq}, 32'd1);

        // Reset abandons the pending request at 0x14
        cyc(1, 0, 32'h0, 0, 0, 0, 0, 0);
        chk_reset_outs("rst2");

        // 4: J 0x40 fetched from PC 0
        cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("t4_addr0", imem_bus.ImemAddr, 32'h0);
        cyc(0, 1, 32'h0800_0040, 0, 1, 26'h40, 0, 0);
        chk("t4_valid", {31'd0, FetchValid_IF}, 32'd1);
        chk("t4_data",  FetchData_IF, 32'h0800_0040);
        cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("t4_addr_tgt", imem_bus.ImemAddr, 32'h100);
        chk("t4_valid_ft", {31'd0, FetchValid_IF}, 32'd0);

        // 5: branch with request pending -> drop stale ack
        cyc(0, 0, 32'h0, 0, 0, 0, 1, 32'h203);
        chk("t5_flush", {31'd0, FetchFlush_IF}, 32'd1);
        chk("t5_valid", {31'd0, FetchValid_IF}, 32'd0);
        cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        chk("t5_stale_valid", {31'd0, FetchValid_IF}, 32'd0);
        chk("t5_stale_data",  FetchData_IF, 32'h0);
        cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("t5_addr", imem_bus.ImemAddr, 32'h200);

        // Branch with ack in S_REQ beats a simultaneous jump
        cyc(0, 1, 32'h0800_0040, 0, 1, 26'h40, 1, 32'h400);
        chk("bj_valid", {31'd0, FetchValid_IF}, 32'd0);
        chk("bj_flush", {31'd0, FetchFlush_IF}, 32'd1);
        cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("bj_addr", imem_bus.ImemAddr, 32'h400);

        // 6: two redirects while dropping, newest wins; then reset mid-request
        cyc(0, 0, 32'h0, 0, 0, 0, 1, 32'h500);
        cyc(0, 0, 32'h0, 0, 0, 0, 1, 32'h300);
        chk("t6_drop_addr", imem_bus.ImemAddr, 32'h400);
        chk("t6_drop_req",  {31'd0, imem_bus.ImemReq}, 32'd1);
        cyc(0, 1, 32'h1111_1111, 0, 0, 0, 0, 0);
        chk("t6_drop_valid", {31'd0, FetchValid_IF}, 32'd0);
        cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("t6_addr", imem_bus.ImemAddr, 32'h300);
        cyc(1, 1, 32'h2222_2222, 0, 0, 0, 1, 32'h600);
        chk_reset_outs("t6_rst");
        cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("t6_addr_rst", imem_bus.ImemAddr, 32'h0);

        // PC wrap at the top of the address space
        cyc(0, 1, 32'h0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("wrap_addr", imem_bus.ImemAddr, 32'hFFFF_FFFC);
        chk("wrap_pc4",  PcPlus4_IF, 32'h0);
        cyc(0, 1, 32'h2005_0005, 0, 0, 0, 0, 0);
        cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("wrap_addr0", imem_bus.ImemAddr, 32'h0);

        // Branch while holding a stalled instruction
        cyc(0, 1, 32'h2006_0006, 1, 0, 0, 0, 0);
        cyc(0, 0, 32'h0, 1, 0, 0, 1, 32'h80);
        chk("have_br_valid", {31'd0, FetchValid_IF}, 32'd0);
        chk("have_br_flush", {31'd0, FetchFlush_IF}, 32'd1);
        cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("have_br_addr", imem_bus.ImemAddr, 32'h80);
        chk("have_br_req",  {31'd0, imem_bus.ImemReq}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
